// File: rtl/branch_metric_pq_if.sv
// Handshake bundle for branch_metric_pq: table load, symbol in, metrics out.
// The DUT takes the slave modport; the driver/ACS side takes master.
`timescale 1ns/1ps
interface branch_metric_pq_if #(
  parameter int N_OUT      = 6,
  parameter int STATE_BITS = 8,
  parameter int RADIX_BITS = 2,
  parameter int Q          = 3
);
  localparam int NUM_BR = 1 << (STATE_BITS + RADIX_BITS);
  localparam int BM_W   = $clog2(N_OUT * ((1 << Q) - 1) + 1);

  logic                   i_load_start;
  logic                   i_cfg_we;
  logic [N_OUT-1:0]       i_cfg_data;
  logic                   o_load_done;
  logic                   i_sym_valid;
  logic                   o_sym_ready;
  logic [N_OUT*Q-1:0]     i_sym;
  logic [N_OUT-1:0]       i_erase;
  logic                   i_mode;
  logic                   o_dist_valid;
  logic                   i_dist_ready;
  logic [NUM_BR*BM_W-1:0] o_dist;

  modport slave (
    input  i_load_start, i_cfg_we, i_cfg_data,
    input  i_sym_valid, i_sym, i_erase, i_mode,
    input  i_dist_ready,
    output o_load_done, o_sym_ready,
    output o_dist_valid, o_dist
  );

  modport master (
    output i_load_start, i_cfg_we, i_cfg_data,
    output i_sym_valid, i_sym, i_erase, i_mode,
    output i_dist_ready,
    input  o_load_done, o_sym_ready,
    input  o_dist_valid, o_dist
  );
endinterface

// File: rtl/branch_metric_pq.sv
// Viterbi branch-metric unit: loadable codeword table, hard/soft/erased
// per-bit distances, 2-stage valid/ready pipeline feeding ACS.
`timescale 1ns/1ps
module branch_metric_pq #(
  parameter int N_OUT      = 6,
  parameter int STATE_BITS = 8,
  parameter int RADIX_BITS = 2,
  parameter int Q          = 3
) (
  input logic             clk,
  input logic             rst,
  branch_metric_pq_if.slave bus
);
  localparam int IDX_W  = STATE_BITS + RADIX_BITS;
  localparam int NUM_BR = 1 << IDX_W;
  localparam int BM_W   = $clog2(N_OUT * ((1 << Q) - 1) + 1);
  localparam int SYM_W  = N_OUT * Q;
  localparam logic [Q-1:0] QMAX = '1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       cnt;
  logic                   load_done;
  logic [N_OUT-1:0]       tbl [NUM_BR];

  logic                   s1_valid;
  logic                   s1_mode;
  logic [SYM_W-1:0]       s1_sym;
  logic [N_OUT-1:0]       s1_erase;
  logic                   s2_valid;
  logic [NUM_BR*BM_W-1:0] s2_dist;
  logic [NUM_BR*BM_W-1:0] metric;

  logic                   advance;
  logic                   accept;
  logic                   tbl_we;
  logic [BM_W-1:0]        acc;
  logic [Q-1:0]           smp;
  logic [Q-1:0]           d;

  assign advance          = !s2_valid || bus.i_dist_ready;
  assign bus.o_sym_ready  = (state == RUN) && advance;
  assign accept           = bus.i_sym_valid && bus.o_sym_ready;
  assign tbl_we           = (state == LOAD) && bus.i_cfg_we &&
                            !bus.i_load_start;
  assign bus.o_load_done  = load_done;
  assign bus.o_dist_valid = s2_valid;
  assign bus.o_dist       = s2_dist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      load_done <= 1'b0;
    end else if (bus.i_load_start) begin
      state     <= LOAD;
      cnt       <= '0;
      load_done <= 1'b0;
    end else if (tbl_we) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        state     <= RUN;
        load_done <= 1'b1;
      end
    end
  end

  // Table is plain storage; RUN gating makes stale contents harmless.
  always_ff @(posedge clk) begin
    if (tbl_we)
      tbl[cnt] <= bus.i_cfg_data;
  end

  always_comb begin
    metric = '0;
    acc    = '0;
    smp    = '0;
    d      = '0;
    for (int b = 0; b < NUM_BR; b++) begin
      acc = '0;
      for (int i = 0; i < N_OUT; i++) begin
        smp = s1_sym[i*Q +: Q];
        if (s1_erase[i])
          d = '0;
        else if (s1_mode)
          d = tbl[b][i] ? QMAX - smp : smp;
        else
          d = Q'(smp[Q-1] ^ tbl[b][i]);
        acc = acc + BM_W'(d);
      end
      metric[b*BM_W +: BM_W] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_sym   <= '0;
      s1_erase <= '0;
      s2_valid <= 1'b0;
      s2_dist  <= '0;
    end else if (bus.i_load_start) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_dist  <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_sym   <= bus.i_sym;
        s1_erase <= bus.i_erase;
        s1_mode  <= bus.i_mode;
      end
      s2_valid <= s1_valid;
      if (s1_valid)
        s2_dist <= metric;
    end
  end
endmodule

// File: tb/tb_branch_metric_pq.sv
// Directed bench for branch_metric_pq with a queue-based reference model
// checked every cycle the metrics are valid.
`timescale 1ns/1ps
module tb_branch_metric_pq;
  localparam int N_OUT      = 6;
  localparam int STATE_BITS = 8;
  localparam int RADIX_BITS = 2;
  localparam int Q          = 3;
  localparam int NUM_BR     = 1 << (STATE_BITS + RADIX_BITS);
  localparam int BM_W       = 6;
  localparam int DW         = NUM_BR * BM_W;
  localparam int SW         = N_OUT * Q;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_metric_pq_if #(
    .N_OUT(N_OUT), .STATE_BITS(STATE_BITS),
    .RADIX_BITS(RADIX_BITS), .Q(Q)
  ) bus ();

  branch_metric_pq #(
    .N_OUT(N_OUT), .STATE_BITS(STATE_BITS),
    .RADIX_BITS(RADIX_BITS), .Q(Q)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_out = 0;
  logic [5:0]    tb_tbl [NUM_BR];
  logic [DW-1:0] exp_q [$];

  // Distances straight from the definition: |sample - ideal level|
  // in soft mode, sign-bit disagreement in hard mode.
  function automatic logic [DW-1:0] model(
    input logic [SW-1:0] sym, input logic [N_OUT-1:0] er, input logic md);
    logic [DW-1:0] r;
    int sum, s, c, lvl;
    r = '0;
    for (int b = 0; b < NUM_BR; b++) begin
      sum = 0;
      for (int i = 0; i < N_OUT; i++) begin
        if (!er[i]) begin
          s   = int'(sym[i*Q +: Q]);
          c   = int'(tb_tbl[b][i]);
          lvl = c * ((1 << Q) - 1);
          if (md)
            sum += (s > lvl) ? s - lvl : lvl - s;
          else
            sum += ((s >= (1 << (Q - 1))) != (c == 1)) ? 1 : 0;
        end
      end
      r[b*BM_W +: BM_W] = BM_W'(sum);
    end
    return r;
  endfunction

  function automatic int br(input int b);
    return int'(bus.o_dist[b*BM_W +: BM_W]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_vec(input string nm,
                         input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int fb;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      fb = 0;
      for (int b = NUM_BR - 1; b >= 0; b--)
        if (act[b*BM_W +: BM_W] !== exp[b*BM_W +: BM_W]) fb = b;
      $display("FAIL %s: branch %0d got %0d required %0d", nm, fb,
               act[fb*BM_W +: BM_W], exp[fb*BM_W +: BM_W]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (bus.o_dist_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_extra: o_dist_valid 1 required 0");
        end else begin
          cmp_vec("sb_dist", bus.o_dist, exp_q[0]);
        end
      end
      if (bus.i_load_start) begin
        exp_q.delete();
      end else begin
        if (bus.o_dist_valid && bus.i_dist_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          n_out++;
        end
        if (bus.i_sym_valid && bus.o_sym_ready)
          exp_q.push_back(model(bus.i_sym, bus.i_erase, bus.i_mode));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writes(input int n, input bit use_idx);
    for (int k = 0; k < n; k++) begin
      bus.i_cfg_we   = 1'b1;
      bus.i_cfg_data = use_idx ? 6'(k) : 6'h3f;
      if (use_idx) tb_tbl[k] = 6'(k);
      if (use_idx && k == NUM_BR - 1)
        chk("load_done_before_last", int'(bus.o_load_done), 0);
      tick();
    end
    bus.i_cfg_we = 1'b0;
  endtask

  task automatic start_load();
    bus.i_load_start = 1'b1;
    tick();
    bus.i_load_start = 1'b0;
  endtask

  task automatic push(input logic [SW-1:0] sym,
                      input logic [N_OUT-1:0] er, input logic md);
    bit ok;
    int n;
    bus.i_sym_valid = 1'b1;
    bus.i_sym       = sym;
    bus.i_erase     = er;
    bus.i_mode      = md;
    ok = 1'b0;
    n  = 0;
    do begin
      @(negedge clk);
      ok = bus.o_sym_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("push_timeout", 0, 1);
    bus.i_sym_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] mv;
    int n0;
    bus.i_load_start = 1'b0;
    bus.i_cfg_we     = 1'b0;
    bus.i_cfg_data   = '0;
    bus.i_sym_valid  = 1'b0;
    bus.i_sym        = '0;
    bus.i_erase      = '0;
    bus.i_mode       = 1'b0;
    bus.i_dist_ready = 1'b1;

    #1;
    chk("rst_load_done", int'(bus.o_load_done), 0);
    chk("rst_sym_ready", int'(bus.o_sym_ready), 0);
    chk("rst_dist_valid", int'(bus.o_dist_valid), 0);
    chk("rst_dist_b63", br(63), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("idle_sym_ready", int'(bus.o_sym_ready), 0);

    start_load();
    writes(NUM_BR, 1'b1);
    chk("load_done", int'(bus.o_load_done), 1);
    // An extra write would land on entry 0 if it were honoured.
    bus.i_cfg_we   = 1'b1;
    bus.i_cfg_data = 6'h3f;
    tick();
    bus.i_cfg_we = 1'b0;
    chk("load_done_hold", int'(bus.o_load_done), 1);

    mv = model('0, '0, 1'b0);
    chk("model_hard_b14", int'(mv[14*BM_W +: BM_W]), 3);
    mv = model({6{3'd3}}, '0, 1'b1);
    chk("model_soft_b0", int'(mv[0 +: BM_W]), 18);

    push('0, '0, 1'b0);
    chk("lat_early", int'(bus.o_dist_valid), 0);
    tick();
    chk("lat_valid", int'(bus.o_dist_valid), 1);
    chk("hard_b14", br(14), 3);
    chk("hard_b0", br(0), 0);
    chk("hard_b63", br(63), 6);

    push({6{3'd7}}, '0, 1'b1);
    tick();
    chk("soft7_b14", br(14), 21);
    push({6{3'd3}}, '0, 1'b1);
    tick();
    chk("soft3_b14", br(14), 21);
    chk("soft3_b0", br(0), 18);

    push(18'h2a5c3, 6'h3f, 1'b1);
    tick();
    chk("erase_all_b14", br(14), 0);
    chk("erase_all_b1023", br(1023), 0);
    chk("erase_all_b500", br(500), 0);
    push('0, 6'h01, 1'b0);
    tick();
    chk("erase1_b1", br(1), 0);
    chk("erase1_b3", br(3), 1);
    repeat (3) tick();

    n0 = n_out;
    bus.i_dist_ready = 1'b0;
    push({6{3'd1}}, '0, 1'b1);
    push({6{3'd6}}, '0, 1'b1);
    chk("bp_ready", int'(bus.o_sym_ready), 0);
    fork
      begin
        push({6{3'd4}}, 6'h12, 1'b1);
        push(18'h0a3f1, '0, 1'b0);
      end
      begin
        repeat (3) begin
          tick();
          chk("bp_ready_hold", int'(bus.o_sym_ready), 0);
          chk("bp_valid_hold", int'(bus.o_dist_valid), 1);
        end
        bus.i_dist_ready = 1'b1;
      end
    join
    repeat (4) tick();
    chk("bp_count", n_out - n0, 4);
    chk("bp_drained", int'(bus.o_dist_valid), 0);

    push('0, '0, 1'b0);
    bus.i_load_start = 1'b1;
    tick();
    bus.i_load_start = 1'b0;
    chk("abort_valid", int'(bus.o_dist_valid), 0);
    chk("abort_load_done", int'(bus.o_load_done), 0);
    chk("abort_sym_ready", int'(bus.o_sym_ready), 0);
    chk("abort_dist_b63", br(63), 0);
    tick();
    chk("abort_valid2", int'(bus.o_dist_valid), 0);
    writes(NUM_BR, 1'b1);
    chk("reload_done", int'(bus.o_load_done), 1);

    push('0, '0, 1'b0);
    tick();
    chk("pre_rst_b63", br(63), 6);
    #3 rst = 1'b0;
    #1;
    chk("arst_load_done", int'(bus.o_load_done), 0);
    chk("arst_dist_valid", int'(bus.o_dist_valid), 0);
    chk("arst_sym_ready", int'(bus.o_sym_ready), 0);
    chk("arst_dist_b63", br(63), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    writes(NUM_BR, 1'b0);
    chk("idle_we_ignored", int'(bus.o_load_done), 0);
    chk("idle_we_ready", int'(bus.o_sym_ready), 0);
    start_load();
    writes(NUM_BR - 1, 1'b1);
    chk("partial_load", int'(bus.o_load_done), 0);
    bus.i_cfg_we   = 1'b1;
    bus.i_cfg_data = 6'(NUM_BR - 1);
    tick();
    bus.i_cfg_we = 1'b0;
    chk("full_reload", int'(bus.o_load_done), 1);
    push('0, '0, 1'b0);
    tick();
    chk("final_b14", br(14), 3);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
